dfi_log_writer: RTL and testbench

Producer end of the direct-DFI log ring. Accepts store-event records (log ID + written data) from the instrumented datapath, buffers them in a small FIFO, writes each as a 64-bit log entry into the circular log table in memory, and publishes the updated write pointer to the DFI checker with a one-cycle trigger. It is the writer of the table the checker consumes: the checker reads entries up to the published pointer and returns its own read pointer for full detection.

---
 rtl/dfi_log_writer.sv | 139 +++++++++++++
 tb/tb_dfi_log_writer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfi_log_writer.sv
// Producer side of the direct-DFI log ring: event FIFO, log-entry writer, pointer publish.
// Optional DFI_LOGW_TIMESTAMP_EN stamps entries [63:40] with a 24-bit cycle counter.
module dfi_log_writer #(
  parameter int N_ADDR_WIDTH     = 32,
  parameter int N_DATA_WIDTH     = 32,
  parameter int N_LOGID_WIDTH    = 8,
  parameter int N_LOG_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH       = 4,
  parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDRINIT = 32'h1FEFFC00,
  parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_RANGE    = 32'h00000400
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_logValid,
  input  logic [N_LOGID_WIDTH-1:0]    i_logId,
  input  logic [N_DATA_WIDTH-1:0]     i_logData,
  output logic                        o_logReady,
  input  logic [N_ADDR_WIDTH-1:0]     i_consPtr,
  output logic                        o_wrReq,
  output logic [N_ADDR_WIDTH-1:0]     o_wrAddr,
  output logic [N_LOG_DATA_WIDTH-1:0] o_wrData,
  input  logic                        i_wrDone,
  output logic                        o_trigger,
  output logic [N_ADDR_WIDTH-1:0]     o_logAddrptr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef DFI_LOGW_TIMESTAMP_EN
  localparam int TS_W = 24;
`else
  localparam int TS_W = 0;
`endif
  localparam int FW = TS_W + N_LOGID_WIDTH + N_DATA_WIDTH;

  localparam logic [N_ADDR_WIDTH-1:0] ADDR_END =
    LOGTABLE_ADDRINIT + LOGTABLE_RANGE - N_ADDR_WIDTH'(8);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  function automatic logic [N_ADDR_WIDTH-1:0] next_ptr(
    input logic [N_ADDR_WIDTH-1:0] p
  );
    return (p >= ADDR_END) ? LOGTABLE_ADDRINIT
                           : p + N_ADDR_WIDTH'(8);
  endfunction

  state_t                  state;
  logic [N_ADDR_WIDTH-1:0] wr_ptr;
  logic [FW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_idx;
  logic [AW-1:0]           rd_idx;
  logic [AW:0]             count;
  logic [FW-1:0]           push_word;
  logic [FW-1:0]           head;
  logic                    fifo_empty;
  logic                    ring_full;
  logic                    push;
  logic                    pop;

`ifdef DFI_LOGW_TIMESTAMP_EN
  logic [23:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (!rst) ts_cnt <= '0;
    else      ts_cnt <= ts_cnt + 24'd1;
  end

  assign push_word = {ts_cnt, i_logId, i_logData};
`else
  assign push_word = {i_logId, i_logData};
`endif

  assign head       = mem[rd_idx];
  assign fifo_empty = (count == '0);
  assign o_logReady = (count != (AW+1)'(FIFO_DEPTH));
  // One slot stays empty so wr_ptr == consumer means an empty ring.
  assign ring_full  = (next_ptr(wr_ptr) == i_consPtr);
  assign push       = i_logValid && o_logReady;
  assign pop        = (state == S_IDLE) && !fifo_empty && !ring_full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      wr_ptr       <= LOGTABLE_ADDRINIT;
      o_wrReq      <= 1'b0;
      o_wrAddr     <= '0;
      o_wrData     <= '0;
      o_trigger    <= 1'b0;
      o_logAddrptr <= LOGTABLE_ADDRINIT;
    end else begin
      o_trigger <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            o_wrData <= N_LOG_DATA_WIDTH'(head);
            o_wrAddr <= wr_ptr;
            o_wrReq  <= 1'b1;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (i_wrDone) begin
            o_wrReq <= 1'b0;
            wr_ptr  <= next_ptr(wr_ptr);
            state   <= S_PUBLISH;
          end
        end
        S_PUBLISH: begin
          o_logAddrptr <= wr_ptr;
          o_trigger    <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfi_log_writer.sv
// Bench for dfi_log_writer: scoreboard of expected entries, memory responder,
// pointer/trigger monitor; optional timestamp scenario under DFI_LOGW_TIMESTAMP_EN.
module tb_dfi_log_writer;

  localparam logic [31:0] BASE = 32'h1FEFFC00;
  localparam logic [31:0] AEND = 32'h1FEFFFF8;
`ifdef DFI_LOGW_TIMESTAMP_EN
  localparam logic [63:0] DMASK = 64'h000000FF_FFFFFFFF;
`else
  localparam logic [63:0] DMASK = 64'hFFFFFFFF_FFFFFFFF;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_logValid = 1'b0;
  logic [7:0]  i_logId = '0;
  logic [31:0] i_logData = '0;
  logic        o_logReady;
  logic [31:0] i_consPtr = BASE;
  logic        o_wrReq;
  logic [31:0] o_wrAddr;
  logic [63:0] o_wrData;
  logic        i_wrDone = 1'b0;
  logic        o_trigger;
  logic [31:0] o_logAddrptr;

  dfi_log_writer dut (
    .clk          (clk),
    .rst          (rst),
    .i_logValid   (i_logValid),
    .i_logId      (i_logId),
    .i_logData    (i_logData),
    .o_logReady   (o_logReady),
    .i_consPtr    (i_consPtr),
    .o_wrReq      (o_wrReq),
    .o_wrAddr     (o_wrAddr),
    .o_wrData     (o_wrData),
    .i_wrDone     (i_wrDone),
    .o_trigger    (o_trigger),
    .o_logAddrptr (o_logAddrptr)
  );

  initial forever #5 clk = ~clk;

  int          vecs = 0;
  int          errs = 0;
  logic [63:0] sb [$];
  logic [31:0] addr_log [$];
  logic [63:0] data_log [$];
  int          n_req = 0;
  int          n_trig = 0;
  int          resp_lat = 2;
  logic [31:0] wr_exp = BASE;
  logic [31:0] last_ptr = BASE;
  logic [23:0] tb_cnt = '0;
  logic        busy = 1'b0;
  logic        done_sent = 1'b0;
  logic        prev_trig = 1'b0;
  int          wcnt = 0;
  logic [31:0] cur_addr = '0;
  logic [63:0] cur_data = '0;

  function automatic logic [31:0] nxt(input logic [31:0] p);
    return (p >= AEND) ? BASE : p + 32'd8;
  endfunction

  // Memory responder plus scoreboard/pointer checks, sampled 1 after each edge.
  task automatic run_monitor();
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        tb_cnt = '0; busy = 0; done_sent = 0; i_wrDone = 0;
        wr_exp = BASE; last_ptr = BASE; prev_trig = 0;
        sb.delete();
      end else begin
        tb_cnt = tb_cnt + 24'd1;
        i_wrDone = 1'b0;
        vecs++;
        if (o_trigger) begin
          n_trig++;
          if (o_logAddrptr !== wr_exp || prev_trig) begin
            errs++;
            $display("FAIL trigger_ptr: got %h (prev_trig %0b) required %h",
                     o_logAddrptr, prev_trig, wr_exp);
          end
        end else if (o_logAddrptr !== last_ptr) begin
          errs++;
          $display("FAIL ptr_stable: got %h required %h", o_logAddrptr, last_ptr);
        end
        last_ptr  = o_logAddrptr;
        prev_trig = o_trigger;
        if (o_wrReq) begin
          vecs++;
          if (!busy) begin
            busy = 1; done_sent = 0; wcnt = 0; n_req++;
            cur_addr = o_wrAddr; cur_data = o_wrData;
            addr_log.push_back(o_wrAddr);
            data_log.push_back(o_wrData);
            if (sb.size() == 0) begin
              errs++;
              $display("FAIL unexpected_write: got %h:%h required none", o_wrAddr, o_wrData);
            end else begin
              e = sb.pop_front();
              if ({o_wrAddr, o_wrData} !== {wr_exp, e}) begin
                errs++;
                $display("FAIL write_entry: got %h:%h required %h:%h",
                         o_wrAddr, o_wrData, wr_exp, e);
              end
            end
          end else if (o_wrAddr !== cur_addr || o_wrData !== cur_data) begin
            errs++;
            $display("FAIL write_hold: got %h:%h required %h:%h",
                     o_wrAddr, o_wrData, cur_addr, cur_data);
          end
          if (!done_sent) begin
            if (wcnt >= resp_lat) begin
              i_wrDone = 1'b1; done_sent = 1; wr_exp = nxt(wr_exp);
            end else begin
              wcnt++;
            end
          end
        end else begin
          busy = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; i_logValid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send(input logic [7:0] id, input logic [31:0] d);
    int t = 0;
    logic [23:0] ts;
    @(negedge clk);
    i_logValid = 1'b1; i_logId = id; i_logData = d;
    while (!o_logReady && t < 3000) begin
      @(negedge clk);
      t++;
    end
`ifdef DFI_LOGW_TIMESTAMP_EN
    ts = tb_cnt;
`else
    ts = 24'h0;
`endif
    if (o_logReady) sb.push_back({ts, id, d});
    @(negedge clk);
    i_logValid = 1'b0;
  endtask

  task automatic wait_trig(input int target);
    int t = 0;
    while (n_trig < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (o_wrReq !== 1'b0) begin errs++; $display("FAIL rst_wrReq: got %b required 0", o_wrReq); end
    vecs++; if (o_wrAddr !== 32'h0) begin errs++; $display("FAIL rst_wrAddr: got %h required 0", o_wrAddr); end
    vecs++; if (o_wrData !== 64'h0) begin errs++; $display("FAIL rst_wrData: got %h required 0", o_wrData); end
    vecs++; if (o_trigger !== 1'b0) begin errs++; $display("FAIL rst_trigger: got %b required 0", o_trigger); end
    vecs++; if (o_logAddrptr !== BASE) begin errs++; $display("FAIL rst_ptr: got %h required %h", o_logAddrptr, BASE); end
    vecs++; if (o_logReady !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b required 1", o_logReady); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    int tg;
    do_reset();
    i_consPtr = BASE; resp_lat = 2; tg = n_trig;
    send(8'h03, 32'hDEADBEEF);
    wait_trig(tg + 1);
    vecs++; if (n_trig !== tg + 1) begin errs++; $display("FAIL single_trig: got %0d required %0d", n_trig, tg + 1); end
    vecs++; if (cur_addr !== 32'h1FEFFC00) begin errs++; $display("FAIL single_addr: got %h required 1feffc00", cur_addr); end
    vecs++; if ((cur_data & DMASK) !== 64'h00000003DEADBEEF) begin errs++; $display("FAIL single_data: got %h required 00000003deadbeef", cur_data); end
    vecs++; if (o_logAddrptr !== 32'h1FEFFC08) begin errs++; $display("FAIL single_ptr: got %h required 1feffc08", o_logAddrptr); end
  endtask

  task automatic test_back_to_back();
    int tg;
    do_reset();
    i_consPtr = BASE; resp_lat = 0; tg = n_trig;
    fork
      for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), $urandom);
    join_none
    wait_trig(tg + 8);
    vecs++; if (n_trig !== tg + 8) begin errs++; $display("FAIL b2b_trig: got %0d required %0d", n_trig, tg + 8); end
    vecs++; if (o_logAddrptr !== BASE + 32'd64) begin errs++; $display("FAIL b2b_ptr: got %h required %h", o_logAddrptr, BASE + 32'd64); end
  endtask

  task automatic test_wrap();
    int tg;
    do_reset();
    resp_lat = 1; addr_log.delete(); tg = n_trig;
    for (int i = 0; i < 129; i++) begin
      i_consPtr = (wr_exp == BASE) ? AEND : wr_exp - 32'd8;
      send(8'(i), 32'hC0DE0000 + 32'(i));
      wait_trig(tg + i + 1);
      if (i == 127) begin
        vecs++; if (o_logAddrptr !== BASE) begin errs++; $display("FAIL wrap_ptr: got %h required %h", o_logAddrptr, BASE); end
      end
    end
    vecs++; if (n_trig !== tg + 129) begin errs++; $display("FAIL wrap_trig: got %0d required %0d", n_trig, tg + 129); end
    vecs++;
    if (addr_log.size() < 129) begin
      errs++; $display("FAIL wrap_count: got %0d required 129", addr_log.size());
    end else if (addr_log[127] !== AEND || addr_log[128] !== BASE) begin
      errs++; $display("FAIL wrap_addr: got %h,%h required %h,%h", addr_log[127], addr_log[128], AEND, BASE);
    end
  endtask

  task automatic test_full();
    int tg, rq;
    do_reset();
    i_consPtr = BASE; resp_lat = 0; addr_log.delete(); tg = n_trig;
    for (int i = 0; i < 127; i++) begin
      send(8'h80, 32'(i));
      wait_trig(tg + i + 1);
    end
    vecs++; if (o_logAddrptr !== AEND) begin errs++; $display("FAIL full_ptr: got %h required %h", o_logAddrptr, AEND); end
    rq = n_req; tg = n_trig;
    send(8'hF0, 32'h00000128);
    repeat (10) @(negedge clk);
    vecs++; if (n_req !== rq || o_wrReq !== 1'b0) begin errs++; $display("FAIL full_block: got %0d reqs required %0d", n_req, rq); end
    send(8'hF1, 32'h1); send(8'hF2, 32'h2);
    vecs++; if (o_logReady !== 1'b1) begin errs++; $display("FAIL full_ready3: got %b required 1", o_logReady); end
    send(8'hF3, 32'h3);
    vecs++; if (o_logReady !== 1'b0) begin errs++; $display("FAIL full_ready4: got %b required 0", o_logReady); end
    @(negedge clk);
    i_consPtr = BASE + 32'd8;
    wait_trig(tg + 1);
    repeat (10) @(negedge clk);
    vecs++; if (n_req !== rq + 1) begin errs++; $display("FAIL full_release: got %0d reqs required %0d", n_req, rq + 1); end
    vecs++; if (addr_log.size() == 0 || addr_log[$] !== AEND) begin errs++; $display("FAIL full_addr: required %h", AEND); end
    vecs++; if (o_logReady !== 1'b1) begin errs++; $display("FAIL full_ready_after: got %b required 1", o_logReady); end
  endtask

  task automatic test_hold();
    int tg, rq;
    do_reset();
    i_consPtr = BASE; resp_lat = 20; rq = n_req; tg = n_trig;
    fork
      for (int i = 0; i < 6; i++) send(8'h40 + 8'(i), 32'hA5A50000 + 32'(i));
    join_none
    repeat (16) @(negedge clk);
    vecs++; if (o_logReady !== 1'b0) begin errs++; $display("FAIL hold_ready: got %b required 0", o_logReady); end
    vecs++; if (n_req !== rq + 1 || o_wrReq !== 1'b1) begin errs++; $display("FAIL hold_req: got %0d reqs required %0d", n_req, rq + 1); end
    wait_trig(tg + 6);
    vecs++; if (n_trig !== tg + 6) begin errs++; $display("FAIL hold_trig: got %0d required %0d", n_trig, tg + 6); end
    vecs++; if (sb.size() !== 0) begin errs++; $display("FAIL hold_lost: got %0d pending required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int tg, t;
    do_reset();
    i_consPtr = BASE; resp_lat = 50;
    send(8'h21, 32'h12345678);
    t = 0;
    while (!o_wrReq && t < 20) begin @(negedge clk); t++; end
    vecs++; if (o_wrReq !== 1'b1) begin errs++; $display("FAIL mid_req: got %b required 1", o_wrReq); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vecs++;
    if (o_wrReq !== 1'b0 || o_wrAddr !== 32'h0 || o_wrData !== 64'h0 ||
        o_trigger !== 1'b0 || o_logAddrptr !== BASE || o_logReady !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset: got req %b addr %h data %h trig %b ptr %h rdy %b required reset values",
               o_wrReq, o_wrAddr, o_wrData, o_trigger, o_logAddrptr, o_logReady);
    end
    @(negedge clk);
    rst = 1'b1; resp_lat = 2; tg = n_trig;
    send(8'h22, 32'hCAFEF00D);
    wait_trig(tg + 1);
    vecs++; if (n_trig !== tg + 1 || cur_addr !== BASE) begin errs++; $display("FAIL mid_after: got %h required %h", cur_addr, BASE); end
    vecs++; if (o_logAddrptr !== BASE + 32'd8) begin errs++; $display("FAIL mid_ptr: got %h required %h", o_logAddrptr, BASE + 32'd8); end
  endtask

`ifdef DFI_LOGW_TIMESTAMP_EN
  task automatic test_timestamp();
    int tg, t;
    do_reset();
    i_consPtr = BASE; resp_lat = 1; data_log.delete(); tg = n_trig;
    t = 0;
    while (tb_cnt < 24'd9 && t < 50) begin @(negedge clk); t++; end
    send(8'h31, 32'h0000AAAA);
    t = 0;
    while (tb_cnt < 24'd14 && t < 50) begin @(negedge clk); t++; end
    send(8'h32, 32'h0000BBBB);
    wait_trig(tg + 2);
    vecs++;
    if (data_log.size() < 2) begin
      errs++; $display("FAIL ts_count: got %0d required 2", data_log.size());
    end else if (data_log[0][63:40] !== 24'd10 || data_log[1][63:40] !== 24'd15) begin
      errs++; $display("FAIL ts_value: got %0d,%0d required 10,15", data_log[0][63:40], data_log[1][63:40]);
    end
  endtask
`endif

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_full();
    test_hold();
    test_reset_mid();
`ifdef DFI_LOGW_TIMESTAMP_EN
    test_timestamp();
`endif
    repeat (5) @(negedge clk);
    vecs++;
    if (sb.size() !== 0) begin
      errs++; $display("FAIL leftover: got %0d pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
